// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer: captures a parallel FFT result frame and streams it out one bin per cycle
// over valid/ready. Optional peak tracking is enabled with `define FFT_PEAK_DETECT_EN.
module fft_bin_streamer #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_frame_valid,
  output logic                       o_frame_ready,
  input  logic [WIDTH-1:0]           i_frame_in [SAMPLES],
  output logic                       o_bin_valid,
  input  logic                       i_bin_ready,
  output logic [WIDTH-1:0]           o_bin_data,
  output logic [$clog2(SAMPLES)-1:0] o_bin_index,
  output logic                       o_bin_last,
  output logic                       o_busy
`ifdef FFT_PEAK_DETECT_EN
  ,
  output logic                       o_peak_valid,
  output logic [$clog2(SAMPLES)-1:0] o_peak_index,
  output logic [WIDTH-1:0]           o_peak_value
`endif
);

  localparam int IDX_W = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_hs;
  logic             w_hs_last;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] w_index_inc;
  logic [WIDTH-1:0] r_bin_data;
  logic             r_bin_last;
  logic [WIDTH-1:0] r_buf [SAMPLES];

  assign w_index_inc = r_index + IDX_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_hs         = 1'b0;
    w_hs_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (i_bin_ready) begin
          w_hs = 1'b1;
          if (r_bin_last) begin
            w_hs_last    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Frame buffer is only written on accept, so a mid-frame frame_valid cannot disturb it.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int i = 0; i < SAMPLES; i++) r_buf[i] <= i_frame_in[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_index    <= '0;
      r_bin_data <= '0;
      r_bin_last <= 1'b0;
    end else if (w_accept) begin
      r_index    <= '0;
      r_bin_data <= i_frame_in[0];
      r_bin_last <= 1'b0;
    end else if (w_hs_last) begin
      r_index    <= '0;
      r_bin_data <= '0;
      r_bin_last <= 1'b0;
    end else if (w_hs) begin
      r_index    <= w_index_inc;
      r_bin_data <= r_buf[w_index_inc];
      r_bin_last <= (w_index_inc == LAST_IDX);
    end
  end

  assign o_frame_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state == ST_STREAM);
  assign o_bin_valid   = (r_state == ST_STREAM);
  assign o_bin_data    = r_bin_data;
  assign o_bin_index   = r_index;
  assign o_bin_last    = r_bin_last;

`ifdef FFT_PEAK_DETECT_EN
  logic [WIDTH-1:0] r_run_value;
  logic [IDX_W-1:0] r_run_index;
  logic             r_peak_valid;
  logic [IDX_W-1:0] r_peak_index;
  logic [WIDTH-1:0] r_peak_value;
  logic             w_new_max;

  // Strict greater-than keeps the earlier index on ties.
  assign w_new_max = (r_bin_data > r_run_value);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_run_value  <= '0;
      r_run_index  <= '0;
      r_peak_valid <= 1'b0;
      r_peak_index <= '0;
      r_peak_value <= '0;
    end else if (w_accept) begin
      r_peak_valid <= 1'b0;
    end else if (w_hs_last) begin
      r_peak_valid <= 1'b1;
      r_peak_value <= w_new_max ? r_bin_data : r_run_value;
      r_peak_index <= w_new_max ? r_index : r_run_index;
    end else if (w_hs) begin
      if (r_index == '0 || w_new_max) begin
        r_run_value <= r_bin_data;
        r_run_index <= r_index;
      end
    end
  end

  assign o_peak_valid = r_peak_valid;
  assign o_peak_index = r_peak_index;
  assign o_peak_value = r_peak_value;
`endif

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed testbench for fft_bin_streamer: basic stream, backpressure, busy-ignore, reset
// mid-frame, and (when FFT_PEAK_DETECT_EN is defined) peak detection.
module tb_fft_bin_streamer;

  localparam int SAMPLES = 8;
  localparam int WIDTH   = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_valid = 1'b0;
  logic              frame_ready;
  logic [WIDTH-1:0]  frame_in [SAMPLES];
  logic              bin_valid;
  logic              bin_ready = 1'b0;
  logic [WIDTH-1:0]  bin_data;
  logic [2:0]        bin_index;
  logic              bin_last;
  logic              busy;
`ifdef FFT_PEAK_DETECT_EN
  logic              peak_valid;
  logic [2:0]        peak_index;
  logic [WIDTH-1:0]  peak_value;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_frame [SAMPLES];

  fft_bin_streamer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_frame_valid (frame_valid),
    .o_frame_ready (frame_ready),
    .i_frame_in    (frame_in),
    .o_bin_valid   (bin_valid),
    .i_bin_ready   (bin_ready),
    .o_bin_data    (bin_data),
    .o_bin_index   (bin_index),
    .o_bin_last    (bin_last),
    .o_busy        (busy)
`ifdef FFT_PEAK_DETECT_EN
    ,
    .o_peak_valid  (peak_valid),
    .o_peak_index  (peak_index),
    .o_peak_value  (peak_value)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7);
    exp_frame[0] = v0; exp_frame[1] = v1; exp_frame[2] = v2; exp_frame[3] = v3;
    exp_frame[4] = v4; exp_frame[5] = v5; exp_frame[6] = v6; exp_frame[7] = v7;
    for (int i = 0; i < SAMPLES; i++) frame_in[i] = exp_frame[i];
  endtask

  // Accepts the frame in exp_frame; returns with bin 0 on the outputs.
  task automatic accept_frame(input string tag);
    check({tag, "_ready_before"}, 32'(frame_ready), 32'd1);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    check({tag, "_valid_k1"}, 32'(bin_valid), 32'd1);
    check({tag, "_busy_k1"}, 32'(busy), 32'd1);
  endtask

  task automatic stream_bins(input string tag, input int first, input int count);
    bin_ready = 1'b1;
    for (int i = first; i < first + count; i++) begin
      check({tag, "_valid"}, 32'(bin_valid), 32'd1);
      check({tag, "_ready0"}, 32'(frame_ready), 32'd0);
      check({tag, "_data"}, bin_data, exp_frame[i]);
      check({tag, "_index"}, 32'(bin_index), 32'(i));
      check({tag, "_last"}, 32'(bin_last), 32'(i == SAMPLES - 1));
      $display("[TB] %s bin %0d data=%0d last=%0d", tag, bin_index, bin_data, bin_last);
      tick();
    end
  endtask

  initial begin
    logic [3:0] pat;
    int k;
    int cyc;
    pat = 4'b1001;
    for (int i = 0; i < SAMPLES; i++) frame_in[i] = '0;

    tick();
    tick();
    check("rst_frame_ready", 32'(frame_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bin_valid", 32'(bin_valid), 32'd0);
    check("rst_bin_data", bin_data, 32'd0);
    check("rst_bin_index", 32'(bin_index), 32'd0);
    check("rst_bin_last", 32'(bin_last), 32'd0);
`ifdef FFT_PEAK_DETECT_EN
    check("rst_peak_valid", 32'(peak_valid), 32'd0);
    check("rst_peak_index", 32'(peak_index), 32'd0);
    check("rst_peak_value", peak_value, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Basic stream
    set_frame(80, 70, 50, 40, 60, 10, 80, 90);
    accept_frame("basic");
    stream_bins("basic", 0, SAMPLES);
    check("basic_end_ready", 32'(frame_ready), 32'd1);
    check("basic_end_valid", 32'(bin_valid), 32'd0);
`ifdef FFT_PEAK_DETECT_EN
    check("peak_basic_valid", 32'(peak_valid), 32'd1);
    check("peak_basic_index", 32'(peak_index), 32'd7);
    check("peak_basic_value", peak_value, 32'd90);
    tick();
    check("peak_basic_hold_idx", 32'(peak_index), 32'd7);
`endif

    // Backpressure: bin_ready pattern 1,0,0,1 repeating
    accept_frame("bp");
    k = 0;
    cyc = 0;
    while (k < SAMPLES && cyc < 64) begin
      bin_ready = pat[cyc % 4];
      check("bp_valid", 32'(bin_valid), 32'd1);
      check("bp_data", bin_data, exp_frame[k]);
      check("bp_index", 32'(bin_index), 32'(k));
      $display("[TB] bp cyc %0d ready=%0d bin %0d data=%0d", cyc, bin_ready, bin_index, bin_data);
      if (bin_ready) k++;
      tick();
      cyc++;
    end
    bin_ready = 1'b0;
    check("bp_handshakes", 32'(k), 32'd8);
    check("bp_end_ready", 32'(frame_ready), 32'd1);
    check("bp_end_valid", 32'(bin_valid), 32'd0);

    // Busy ignore: new frame offered mid-stream must not disturb the held frame
    set_frame(80, 70, 50, 40, 60, 10, 80, 90);
    accept_frame("busy");
    stream_bins("busy", 0, 2);
    frame_valid = 1'b1;
    for (int i = 0; i < SAMPLES; i++) frame_in[i] = 32'(i + 1);
    stream_bins("busy", 2, 3);
    frame_valid = 1'b0;
    stream_bins("busy", 5, 3);
    check("busy_end_ready", 32'(frame_ready), 32'd1);
    check("busy_no_queue", 32'(bin_valid), 32'd0);
    tick();
    check("busy_no_queue2", 32'(bin_valid), 32'd0);

    // Reset mid-frame after bin 3 has been handshaked
    set_frame(80, 70, 50, 40, 60, 10, 80, 90);
    accept_frame("mid");
    stream_bins("mid", 0, 4);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bin_valid), 32'd0);
    check("mid_rst_ready", 32'(frame_ready), 32'd1);
    check("mid_rst_index", 32'(bin_index), 32'd0);
    tick();
    reset = 1'b0;
    bin_ready = 1'b0;
    set_frame(5, 6, 7, 8, 9, 10, 11, 12);
    accept_frame("after_rst");
    stream_bins("after_rst", 0, SAMPLES);
    check("after_rst_end_ready", 32'(frame_ready), 32'd1);

`ifdef FFT_PEAK_DETECT_EN
    // Tie on the maximum keeps the lower index
    set_frame(90, 1, 90, 3, 4, 5, 6, 7);
    accept_frame("tie");
    check("peak_cleared_on_accept", 32'(peak_valid), 32'd0);
    stream_bins("tie", 0, SAMPLES);
    check("peak_tie_valid", 32'(peak_valid), 32'd1);
    check("peak_tie_index", 32'(peak_index), 32'd0);
    check("peak_tie_value", peak_value, 32'd90);
    accept_frame("next");
    check("peak_clear_next", 32'(peak_valid), 32'd0);
    stream_bins("next", 0, SAMPLES);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_bin_streamer.md
# fft_bin_streamer

Output-side companion to `N_Point_FFT`. It captures the FFT's parallel `outputs` vector as one frame and streams the bins out one per cycle over a valid/ready handshake, with bin index and last-bin marker. It sits between the combinational FFT and any serial consumer, such as a UART or FIFO, replacing the hold-the-array-forever style of driving and reading the FFT.

## Interface
- `SAMPLES`, default 8: bins per frame; must be a power of two ≥ 2.
- `WIDTH`, default 32: bits per bin word. The word is treated as opaque, except for the unsigned compare in peak detect.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_valid`  in  1  `frame_in` holds a settled FFT result.
- `frame_ready`  out  1  block can accept a frame.
- `frame_in`  in  `[WIDTH-1:0]` × `[SAMPLES-1:0]`  unpacked array; connects directly to the FFT `outputs` port.
- `bin_valid`  out  1  `bin_data`/`bin_index`/`bin_last` are valid.
- `bin_ready`  in  1  consumer accepts the current bin.
- `bin_data`  out  WIDTH  current bin word.
- `bin_index`  out  `$clog2(SAMPLES)`  index of the current bin.
- `bin_last`  out  1  current bin is index SAMPLES-1.
- `busy`  out  1  a frame is held; equals `!frame_ready`.
- `peak_valid`, `peak_index` (`$clog2(SAMPLES)`), `peak_value` (WIDTH)  out: present only with `FFT_PEAK_DETECT_EN`.

## Operation
- Two states: IDLE and STREAM.
- IDLE:
  - `frame_ready`=1 and `bin_valid`=0.
  - When `frame_valid` is high on a clock edge, all SAMPLES words are copied into an internal buffer, the index is set to 0, and the state moves to STREAM.
- STREAM:
  - `frame_ready`=0 and `bin_valid`=1.
  - `bin_data` = buf[index], `bin_index` = index, `bin_last` = (index == SAMPLES-1).
  - A handshake occurs when `bin_valid` and `bin_ready` are both high on an edge.
  - On a handshake with index < SAMPLES-1: index increments.
  - On a handshake with `bin_last`=1: return to IDLE, index returns to 0.
  - Without a handshake, all bin outputs hold their values (AXI-stream rule). `bin_valid` never drops mid-frame.
- `frame_valid` seen while in STREAM is ignored. The buffer is never overwritten mid-frame, and the frame is not queued.
- `frame_in` is sampled only on the accept edge. Later changes on `frame_in` do not affect the streamed data.
- Index arithmetic is `$clog2(SAMPLES)` bits wide. Increment is suppressed at SAMPLES-1, so the index never wraps past a frame.
- Reset mid-operation: the state immediately returns to IDLE and the held frame is discarded. The next accepted frame starts again at index 0.

## Timing
- Reset values:
  - `frame_ready`=1, `busy`=0, `bin_valid`=0, `bin_data`=0, `bin_index`=0, `bin_last`=0.
  - `peak_valid`=0, `peak_index`=0, `peak_value`=0.
- All outputs are driven from registers. There are no combinational paths from inputs to outputs.
- Accept at edge k gives `bin_valid`=1 with bin 0 during cycle k+1.
- With `bin_ready` held high, bins are emitted one per cycle, so a frame takes SAMPLES cycles.
- After the last-bin handshake at edge m, `frame_ready`=1 in cycle m+1. The earliest next accept is edge m+1. This gives SAMPLES+1 cycles per frame, with one bubble.
- The upstream FFT must have settled before `frame_valid` is asserted. This block adds no settle wait.

## Configuration
- `FFT_PEAK_DETECT_EN` defined:
  - While streaming, the block tracks the largest bin, compared as unsigned, among the bins that have been handshaked.
  - On a tie, the lower index is kept.
  - `peak_valid` rises in the cycle after the last-bin handshake and stays high until the next frame accept or reset.
  - `peak_index` and `peak_value` are stable while `peak_valid`=1.
- `FFT_PEAK_DETECT_EN` undefined: the peak ports and logic are absent. All other behaviour is identical.

## Test plan
- Basic stream: after reset, frame {80,70,50,40,60,10,80,90} with `bin_ready`=1. Required: bins 80..90 on 8 consecutive cycles; indices 0..7; `bin_last` only on index 7; `frame_ready` back to 1 in the following cycle.
- Backpressure: same frame with `bin_ready` toggling 1,0,0,1,… Required: each bin holds steady while `bin_ready`=0; no bin skipped or duplicated; 8 handshakes total.
- Busy ignore: while in STREAM, pulse `frame_valid` with {1..8} and change `frame_in`. Required: the original frame streams intact and `frame_ready` stays 0.
- Reset mid-frame: assert `reset` after bin 3. Required: `bin_valid`=0 immediately; a subsequent frame {5,6,7,8,9,10,11,12} streams from index 0.
- Peak detect (with `FFT_PEAK_DETECT_EN`):
  - Basic frame: `peak_index`=7, `peak_value`=90.
  - Frame {90,1,90,…}: `peak_index`=0 (lower index wins the tie).
  - `peak_valid` clears on the next accept.
